instr_fetch_unit: RTL and testbench

- Fetch stage of the 16-bit MIPS core, directly upstream of the control/decode stage.
- Owns the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Exposes opcode = instr[15:13], which feeds the control unit's 3-bit opcode input. Accepts PC redirects from branch/jump resolution and a halt request.

---
 rtl/core_pkg.sv | 30 +++
 rtl/fetch_queue.sv | 49 ++++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the 16-bit MIPS core pipeline.
// Holds the opcode/instruction typedefs, the fetch FSM states and the fetch queue entry layout.
package core_pkg;

    typedef logic [2:0]  opcode_t;
    typedef logic [15:0] instr_t;

    localparam opcode_t OPC_ADD  = 3'b000;
    localparam opcode_t OPC_SUB  = 3'b001;
    localparam opcode_t OPC_AND  = 3'b010;
    localparam opcode_t OPC_OR   = 3'b011;
    localparam opcode_t OPC_SLT  = 3'b100;
    localparam opcode_t OPC_LW   = 3'b101;
    localparam opcode_t OPC_SW   = 3'b110;
    localparam opcode_t OPC_ADDI = 3'b111;

    localparam logic [15:0] PC_STEP = 16'd2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] pc;
        instr_t      instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small shift-register FIFO of {pc, instr} entries; head is always entry 0.
// Flush wins over push and pop; the producer is responsible for never pushing when full.
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [CW-1:0] wr_idx;

    // A simultaneous pop shifts everything down, so the new entry lands one slot lower.
    assign wr_idx = count - CW'(pop);
    assign head   = mem[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_idx == CW'(i))) begin
                    mem[i] <= push_data;
                end
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads a 1-cycle-latency instruction memory and hands instructions to decode.
// Define IF_PERF_CNT_EN to add the saturating perf_fetch_cnt / perf_bubble_cnt outputs.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_rd_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [2:0]  if_opcode,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_bubble_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t  state, state_next;
    logic [15:0]   fetch_pc, inflight_pc;
    logic          inflight, inflight_epoch, epoch;
    logic [CW-1:0] q_count;
    logic [CW:0]   credit_used;
    logic          q_push, q_pop, issue;
    fetch_entry_t  q_head, push_entry;

    assign if_valid = (q_count != '0);
    assign q_pop    = if_valid & id_ready;

    // A slot being popped this cycle is already free for the fetch issued now, giving 1 instr/cycle.
    assign credit_used = {1'b0, q_count} - (CW+1)'(q_pop) + (CW+1)'(inflight);
    assign issue = reset_n & (state == ST_RUN) & ~redirect_valid & ~halt_req
                 & (credit_used < (CW+1)'(QDEPTH));

    assign imem_rd_en = issue;
    assign imem_addr  = fetch_pc;

    assign q_push           = inflight & (inflight_epoch == epoch) & ~redirect_valid;
    assign push_entry.pc    = inflight_pc;
    assign push_entry.instr = imem_rdata;

    fetch_queue #(.DEPTH(QDEPTH), .CW(CW)) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head      (q_head),
        .count     (q_count)
    );

    assign if_instr    = if_valid ? q_head.instr : '0;
    assign if_pc       = if_valid ? q_head.pc : '0;
    assign if_pc_plus2 = if_valid ? (q_head.pc + PC_STEP) : '0;
    assign if_opcode   = if_instr[15:13];
    assign halted      = (state == ST_HALTED);

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (halt_req && !redirect_valid) state_next = ST_DRAIN;
            ST_DRAIN:  if (redirect_valid || !halt_req) state_next = ST_RUN;
                       else if (!inflight)              state_next = ST_HALTED;
            ST_HALTED: if (redirect_valid || !halt_req) state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    // Redirect toggles the epoch so a response already on its way is recognised as stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_RUN;
            fetch_pc       <= RESET_PC;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= fetch_pc;
                inflight_epoch <= epoch;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & 16'hFFFE;
                epoch    <= ~epoch;
            end else if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (q_pop && (perf_fetch_cnt != 16'hFFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            end
            if (id_ready && !if_valid && (state == ST_RUN) && (perf_bubble_cnt != 16'hFFFF)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based fetch model, directed scenarios, then random traffic.
// Perf counter checks are compiled in when IF_PERF_CNT_EN is defined.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_rd_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt_req = 1'b0;
    logic        id_ready = 1'b1;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [2:0]  if_opcode;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;
`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_bubble_cnt;
`endif

    int checks = 0;
    int failures = 0;

    instr_fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode),
        .if_pc          (if_pc),
        .if_pc_plus2    (if_pc_plus2),
        .halted         (halted)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: word at address a holds 16'h1000 + a, junk when not read.
    always @(posedge clk) begin
        imem_rdata <= imem_rd_en ? (16'h1000 + imem_addr) : 16'hDEAD;
    end

    // Behavioural model: queue of delivered PCs, one optional outstanding fetch, run/drain/halted mode.
    int          m_q[$];
    logic [15:0] m_pc = 16'h0000;
    bit          m_pend = 1'b0;
    logic [15:0] m_pend_pc = 16'h0000;
    int          m_mode = 0;
    int          m_fetch = 0;
    int          m_bubble = 0;

    function automatic bit m_valid();
        return m_q.size() > 0;
    endfunction

    function automatic bit m_issue();
        int used;
        used = m_q.size() - ((m_valid() && id_ready) ? 1 : 0) + (m_pend ? 1 : 0);
        return reset_n && (m_mode == 0) && !redirect_valid && !halt_req && (used < 2);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit pop, iss, pend_now;
        if (!reset_n) begin
            m_q.delete();
            m_pc     = 16'h0000;
            m_pend   = 1'b0;
            m_mode   = 0;
            m_fetch  = 0;
            m_bubble = 0;
        end else begin
            pop      = m_valid() && id_ready;
            iss      = m_issue();
            pend_now = m_pend;
            if (pop && m_fetch < 65535) m_fetch++;
            if (id_ready && !m_valid() && m_mode == 0 && m_bubble < 65535) m_bubble++;
            if (redirect_valid) begin
                m_q.delete();
                m_pc   = redirect_pc & 16'hFFFE;
                m_pend = 1'b0;
                m_mode = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (pend_now) m_q.push_back(int'(m_pend_pc));
                m_pend = iss;
                if (iss) begin
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 16'd2;
                end
                case (m_mode)
                    0: if (halt_req) m_mode = 1;
                    1: if (!halt_req) m_mode = 0; else if (!pend_now) m_mode = 2;
                    default: if (!halt_req) m_mode = 0;
                endcase
            end
        end
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input bit rdy, input bit hlt, input bit rdv, input logic [15:0] rpc);
        id_ready       = rdy;
        halt_req       = hlt;
        redirect_valid = rdv;
        redirect_pc    = rpc;
    endtask

    // Cycle-by-cycle comparison against the model, mid-cycle when everything has settled.
    always @(negedge clk) begin
        logic [15:0] e_pc, e_instr;
        bit v;
        v       = m_valid();
        e_pc    = v ? 16'(m_q[0]) : 16'h0000;
        e_instr = v ? (16'h1000 + e_pc) : 16'h0000;
        check_output("m_if_valid", 16'(if_valid), 16'(v));
        check_output("m_if_pc", if_pc, e_pc);
        check_output("m_if_instr", if_instr, e_instr);
        check_output("m_if_opcode", 16'(if_opcode), 16'(e_instr[15:13]));
        check_output("m_if_pc_plus2", if_pc_plus2, v ? e_pc + 16'd2 : 16'h0000);
        check_output("m_imem_rd_en", 16'(imem_rd_en), 16'(m_issue()));
        check_output("m_imem_addr", imem_addr, m_pc);
        check_output("m_halted", 16'(halted), 16'(m_mode == 2));
`ifdef IF_PERF_CNT_EN
        check_output("m_perf_fetch", perf_fetch_cnt, 16'(m_fetch));
        check_output("m_perf_bubble", perf_bubble_cnt, 16'(m_bubble));
`endif
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_zero(input string tag);
        check_output({tag, "_rd_en"}, 16'(imem_rd_en), 16'd0);
        check_output({tag, "_valid"}, 16'(if_valid), 16'd0);
        check_output({tag, "_pc"}, if_pc, 16'h0000);
        check_output({tag, "_instr"}, if_instr, 16'h0000);
        check_output({tag, "_plus2"}, if_pc_plus2, 16'h0000);
        check_output({tag, "_halted"}, 16'(halted), 16'd0);
    endtask

    initial begin
        bit h;
        h = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_zero("rst");

        // Reset release and first fetches
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check_output("c0_rd_en", 16'(imem_rd_en), 16'd1);
        check_output("c0_addr", imem_addr, 16'h0000);
        @(negedge clk);
        check_output("c1_addr", imem_addr, 16'h0002);
        check_output("c1_valid", 16'(if_valid), 16'd0);
        @(negedge clk);
        check_output("c2_valid", 16'(if_valid), 16'd1);
        check_output("c2_pc", if_pc, 16'h0000);
        check_output("c2_instr", if_instr, 16'h1000);
        check_output("c2_opcode", 16'(if_opcode), 16'd0);

        // Backpressure: queue fills, fetch stops, order preserved on release
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (5) @(negedge clk);
        check_output("hold_rd_en", 16'(imem_rd_en), 16'd0);
        check_output("hold_valid", 16'(if_valid), 16'd1);
        check_output("hold_pc", if_pc, 16'h0002);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check_output("rel_pc0", if_pc, 16'h0002);
        @(negedge clk);
        check_output("rel_pc1", if_pc, 16'h0004);
        @(negedge clk);
        check_output("rel_pc2", if_pc, 16'h0006);

        // Redirect while a fetch is in flight
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 1'b1, 16'h0041);
        @(negedge clk);
        check_output("rdr_rd_en", 16'(imem_rd_en), 16'd0);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check_output("rdr_valid", 16'(if_valid), 16'd0);
        check_output("rdr_addr", imem_addr, 16'h0040);
        check_output("rdr_issue", 16'(imem_rd_en), 16'd1);
        @(negedge clk);
        @(negedge clk);
        check_output("rdr_first_valid", 16'(if_valid), 16'd1);
        check_output("rdr_first_pc", if_pc, 16'h0040);
        check_output("rdr_first_instr", if_instr, 16'h1040);

        // PC wrap around the top of the address space
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 1'b1, 16'hFFFC);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check_output("wrap_addr0", imem_addr, 16'hFFFC);
        @(negedge clk);
        check_output("wrap_addr1", imem_addr, 16'hFFFE);
        @(negedge clk);
        check_output("wrap_addr2", imem_addr, 16'h0000);
        check_output("wrap_pc0", if_pc, 16'hFFFC);
        @(negedge clk);
        check_output("wrap_pc1", if_pc, 16'hFFFE);
        check_output("wrap_plus2", if_pc_plus2, 16'h0000);

        // Halt: fetch stops, in-flight fetch lands, queue drains, resume at next PC
        next_cycle();
        apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        check_output("halt_rd_en", 16'(imem_rd_en), 16'd0);
        @(negedge clk);
        @(negedge clk);
        check_output("halt_halted", 16'(halted), 16'd1);
        repeat (3) @(negedge clk);
        check_output("halt_drained", 16'(if_valid), 16'd0);
        check_output("halt_still", 16'(halted), 16'd1);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check_output("resume_rd_en", 16'(imem_rd_en), 16'd1);
        check_output("resume_addr", imem_addr, 16'h0004);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            next_cycle();
            if ($urandom_range(0, 99) < 6) h = !h;
            apply_stimulus($urandom_range(0, 99) < 70, h, $urandom_range(0, 99) < 6, 16'($urandom));
        end

        // Asynchronous reset in the middle of a cycle
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_zero("async");
`ifdef IF_PERF_CNT_EN
        check_output("async_perf_fetch", perf_fetch_cnt, 16'h0000);
        check_output("async_perf_bubble", perf_bubble_cnt, 16'h0000);
`endif
        next_cycle();
        reset_n = 1'b1;
        h = 1'b0;
        for (int i = 0; i < 200; i++) begin
            next_cycle();
            if ($urandom_range(0, 99) < 4) h = !h;
            apply_stimulus($urandom_range(0, 99) < 80, h, $urandom_range(0, 99) < 3, 16'($urandom));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
